// File: rtl/decode_ctrl_pkg.sv
// Shared types and constants for the decode-stage issue controller.
// Control-word offsets let a parent slice the raw decoder word into fields.
package decode_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } dec_ctrl_state_t;

    localparam int REG_ADDR_W = 5;

    localparam int CW_D_ADDR_MSB = 25;
    localparam int CW_D_ADDR_LSB = 21;
    localparam int CW_B_SEL_MSB  = 20;
    localparam int CW_B_SEL_LSB  = 16;
    localparam int CW_A_SEL_MSB  = 15;
    localparam int CW_A_SEL_LSB  = 11;
    localparam int CW_LOAD_BIT   = 4;

endpackage

// File: rtl/decode_issue_controller_if.sv
// Decoder-to-controller handshake: decoded operand fields plus valid/ready.
interface decode_issue_controller_if;
    import decode_ctrl_pkg::*;

    logic                  dec_valid;
    logic                  dec_ready;
    logic [REG_ADDR_W-1:0] dec_d_addr;
    logic [REG_ADDR_W-1:0] dec_a_sel;
    logic [REG_ADDR_W-1:0] dec_b_sel;
    logic                  dec_uses_b;
    logic                  dec_load;

    modport master (
        output dec_valid, dec_d_addr, dec_a_sel, dec_b_sel, dec_uses_b, dec_load,
        input  dec_ready
    );

    modport slave (
        input  dec_valid, dec_d_addr, dec_a_sel, dec_b_sel, dec_uses_b, dec_load,
        output dec_ready
    );
endinterface

// File: rtl/load_scoreboard.sv
// Per-register pending-load bits with same-cycle writeback bypass,
// plus the outstanding-load counter and its full flag.
module load_scoreboard
    import decode_ctrl_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int MAX_LOADS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_issue,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  wb_valid,
    input  logic                  wb_load,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    output logic [REG_COUNT-1:0]  pending_o,
    output logic [REG_COUNT-1:0]  pending_eff_o,
    output logic [3:0]            load_cnt_o,
    output logic                  full_o
);

    logic [REG_COUNT-1:0] pending_q, pending_d;
    logic [REG_COUNT-1:0] set_vec, clr_vec;
    logic [3:0]           load_cnt_q, load_cnt_d;
    logic                 wb_ld;

    assign wb_ld = wb_valid & wb_load;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        set_vec    = '0;
        clr_vec    = '0;
        load_cnt_d = load_cnt_q;
        if (wb_ld && wb_addr != '0)
            clr_vec[wb_addr] = 1'b1;
        if (load_issue && set_addr != '0)
            set_vec[set_addr] = 1'b1;
        // Set is ORed after the clear, so a new load to the same register wins.
        pending_eff_o = pending_q & ~clr_vec;
        pending_d     = pending_eff_o | set_vec;
        if (load_issue && !wb_ld)
            load_cnt_d = load_cnt_q + 4'd1;
        else if (!load_issue && wb_ld && load_cnt_q != 4'd0)
            load_cnt_d = load_cnt_q - 4'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            load_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            load_cnt_q <= load_cnt_d;
        end
    end

    assign pending_o  = pending_q;
    assign load_cnt_o = load_cnt_q;
    // A load writeback this cycle frees a slot, so the counter is not full for this cycle's issue.
    assign full_o     = (load_cnt_q == 4'(MAX_LOADS)) & ~wb_ld;

endmodule

// File: rtl/decode_issue_controller.sv
// Decode-stage sequencer: load-use hazard and load-limit stalls, redirect
// flush window, and same-cycle issue of hazard-free instructions.
module decode_issue_controller
    import decode_ctrl_pkg::*;
#(
    parameter int REG_COUNT    = 32,
    parameter int MAX_LOADS    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    decode_issue_controller_if.slave   dec,
    input  logic                       ex_ready,
    output logic                       issue_valid,
    input  logic                       redirect_valid,
    input  logic                       wb_valid,
    input  logic                       wb_load,
    input  logic [REG_ADDR_W-1:0]      wb_addr,
    output logic                       stall_o,
    output logic                       flush_o,
    output logic [REG_COUNT-1:0]       pending_o,
    output logic [3:0]                 load_cnt_o
);

    dec_ctrl_state_t      state_q, state_d;
    logic [2:0]           flush_cnt_q, flush_cnt_d;
    logic [REG_COUNT-1:0] pending_eff;
    logic                 full;
    logic                 haz, lim, in_flush;

    load_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .MAX_LOADS (MAX_LOADS)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .load_issue    (issue_valid & dec.dec_load),
        .set_addr      (dec.dec_d_addr),
        .wb_valid      (wb_valid),
        .wb_load       (wb_load),
        .wb_addr       (wb_addr),
        .pending_o     (pending_o),
        .pending_eff_o (pending_eff),
        .load_cnt_o    (load_cnt_o),
        .full_o        (full)
    );

    assign in_flush = (state_q == FLUSH);
    assign haz      = pending_eff[dec.dec_a_sel] | (dec.dec_uses_b & pending_eff[dec.dec_b_sel]);
    assign lim      = dec.dec_load & full;

    assign issue_valid   = dec.dec_valid & ex_ready & ~haz & ~lim & ~in_flush
                         & ~redirect_valid & ~reset;
    assign dec.dec_ready = issue_valid;
    assign stall_o       = dec.dec_valid & ~issue_valid & ~in_flush & ~reset;
    assign flush_o       = in_flush;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (redirect_valid) begin
            state_d     = FLUSH;
            flush_cnt_d = 3'(FLUSH_CYCLES);
        end else begin
            unique case (state_q)
                RUN:   if (stall_o) state_d = STALL;
                STALL: if (issue_valid || !dec.dec_valid) state_d = RUN;
                FLUSH: begin
                    if (flush_cnt_q <= 3'd1) begin
                        state_d     = RUN;
                        flush_cnt_d = 3'd0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_decode_issue_controller.sv
// Directed bench for decode_issue_controller with default parameters
// (MAX_LOADS=4, FLUSH_CYCLES=2); expected values are hand-computed.
module tb_decode_issue_controller;
    import decode_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        ex_ready;
    logic        issue_valid;
    logic        redirect_valid;
    logic        wb_valid;
    logic        wb_load;
    logic [4:0]  wb_addr;
    logic        stall_o;
    logic        flush_o;
    logic [31:0] pending_o;
    logic [3:0]  load_cnt_o;

    int n_tests;
    int n_fail;

    decode_issue_controller_if dif ();

    decode_issue_controller dut (
        .clk            (clk),
        .reset          (reset),
        .dec            (dif),
        .ex_ready       (ex_ready),
        .issue_valid    (issue_valid),
        .redirect_valid (redirect_valid),
        .wb_valid       (wb_valid),
        .wb_load        (wb_load),
        .wb_addr        (wb_addr),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .pending_o      (pending_o),
        .load_cnt_o     (load_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dif.dec_valid  = 1'b0;
        dif.dec_d_addr = '0;
        dif.dec_a_sel  = '0;
        dif.dec_b_sel  = '0;
        dif.dec_uses_b = 1'b0;
        dif.dec_load   = 1'b0;
        redirect_valid = 1'b0;
        wb_valid       = 1'b0;
        wb_load        = 1'b0;
        wb_addr        = '0;
        ex_ready       = 1'b1;
    endtask

    task automatic instr(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                         input logic uses_b, input logic ld);
        dif.dec_valid  = 1'b1;
        dif.dec_d_addr = d;
        dif.dec_a_sel  = a;
        dif.dec_b_sel  = b;
        dif.dec_uses_b = uses_b;
        dif.dec_load   = ld;
    endtask

    task automatic wb(input logic [4:0] addr);
        wb_valid = 1'b1;
        wb_load  = 1'b1;
        wb_addr  = addr;
    endtask

    task automatic no_wb();
        wb_valid = 1'b0;
        wb_load  = 1'b0;
        wb_addr  = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        reset = 1'b1;
        dif.dec_valid = 1'b1;
        cyc();
        cyc();
        check("rst_issue", 32'(issue_valid), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_ready", 32'(dif.dec_ready), 32'd0);
        check("rst_pending", pending_o, 32'h0);
        check("rst_cnt", 32'(load_cnt_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        reset = 1'b0;
        idle();

        // Stray load writeback with nothing outstanding: counter holds at 0.
        wb(5'd3);
        cyc();
        no_wb();
        check("sat_cnt", 32'(load_cnt_o), 32'd0);

        // 1: load-use on rs2 path, released by same-cycle writeback.
        instr(5'd5, 5'd1, 5'd2, 1'b0, 1'b1);
        #1 check("lu_lw_issue", 32'(issue_valid), 32'd1);
        cyc();
        check("lu_pending5", pending_o, 32'h0000_0020);
        check("lu_cnt1", 32'(load_cnt_o), 32'd1);
        instr(5'd6, 5'd1, 5'd5, 1'b1, 1'b0);
        #1 check("lu_stall", 32'(stall_o), 32'd1);
        check("lu_noissue", 32'(issue_valid), 32'd0);
        cyc();
        check("lu_hold_pending", pending_o, 32'h0000_0020);
        wb(5'd5);
        #1 check("lu_bypass_issue", 32'(issue_valid), 32'd1);
        check("lu_bypass_ready", 32'(dif.dec_ready), 32'd1);
        check("lu_bypass_nostall", 32'(stall_o), 32'd0);
        cyc();
        no_wb();
        idle();
        check("lu_cleared", pending_o, 32'h0);
        check("lu_cnt0", 32'(load_cnt_o), 32'd0);

        // 2: x0 never pending; unused rs2 ignored.
        instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        #1 check("x0_lw_issue", 32'(issue_valid), 32'd1);
        cyc();
        check("x0_not_pending", pending_o, 32'h0);
        instr(5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        #1 check("x0_addi_issue", 32'(issue_valid), 32'd1);
        cyc();
        idle();
        wb(5'd0);
        cyc();
        no_wb();
        check("x0_cnt_drained", 32'(load_cnt_o), 32'd0);
        instr(5'd9, 5'd0, 5'd0, 1'b0, 1'b1);
        cyc();
        check("x9_pending", pending_o, 32'h0000_0200);
        instr(5'd3, 5'd1, 5'd9, 1'b0, 1'b0);
        #1 check("nouse_b_issue", 32'(issue_valid), 32'd1);
        check("nouse_b_nostall", 32'(stall_o), 32'd0);
        dif.dec_uses_b = 1'b1;
        #1 check("use_b_stall", 32'(stall_o), 32'd1);
        idle();
        wb(5'd9);
        cyc();
        no_wb();
        check("x9_cleared", pending_o, 32'h0);

        // 3: load limit at MAX_LOADS=4.
        for (int i = 1; i <= 4; i++) begin
            instr(5'(i), 5'd0, 5'd0, 1'b0, 1'b1);
            #1 check($sformatf("lim_issue_x%0d", i), 32'(issue_valid), 32'd1);
            cyc();
        end
        check("lim_cnt4", 32'(load_cnt_o), 32'd4);
        check("lim_pending", pending_o, 32'h0000_001E);
        instr(5'd8, 5'd0, 5'd0, 1'b0, 1'b1);
        #1 check("lim_stall", 32'(stall_o), 32'd1);
        check("lim_noissue", 32'(issue_valid), 32'd0);
        cyc();
        wb(5'd1);
        #1 check("lim_wb_issue", 32'(issue_valid), 32'd1);
        cyc();
        no_wb();
        idle();
        check("lim_cnt_stays4", 32'(load_cnt_o), 32'd4);
        check("lim_pending2", pending_o, 32'h0000_011C);
        for (int i = 0; i < 4; i++) begin
            wb(i == 3 ? 5'd8 : 5'(i + 2));
            cyc();
        end
        no_wb();
        check("lim_drain_cnt", 32'(load_cnt_o), 32'd0);
        check("lim_drain_pending", pending_o, 32'h0);

        // 4: set and clear of the same register in one cycle.
        instr(5'd5, 5'd0, 5'd0, 1'b0, 1'b1);
        cyc();
        wb(5'd5);
        #1 check("sc_issue", 32'(issue_valid), 32'd1);
        cyc();
        no_wb();
        idle();
        check("sc_pending5", pending_o, 32'h0000_0020);
        check("sc_cnt1", 32'(load_cnt_o), 32'd1);
        wb(5'd5);
        cyc();
        no_wb();
        check("sc_final_cnt", 32'(load_cnt_o), 32'd0);

        // 5: redirect opens a two-cycle flush window; scoreboard untouched.
        instr(5'd7, 5'd0, 5'd0, 1'b0, 1'b1);
        cyc();
        instr(5'd10, 5'd0, 5'd0, 1'b0, 1'b0);
        redirect_valid = 1'b1;
        #1 check("rd_noissue", 32'(issue_valid), 32'd0);
        check("rd_noflush_yet", 32'(flush_o), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        #1 check("fl1_flush", 32'(flush_o), 32'd1);
        check("fl1_noissue", 32'(issue_valid), 32'd0);
        check("fl1_nostall", 32'(stall_o), 32'd0);
        wb(5'd7);
        cyc();
        no_wb();
        check("fl2_flush", 32'(flush_o), 32'd1);
        check("fl2_pending_clr", pending_o, 32'h0);
        check("fl2_cnt", 32'(load_cnt_o), 32'd0);
        cyc();
        check("fl_done", 32'(flush_o), 32'd0);
        check("fl_run_issue", 32'(issue_valid), 32'd1);
        cyc();
        idle();

        // 6: reset aborts a stall with loads outstanding, and aborts a flush.
        for (int i = 1; i <= 3; i++) begin
            instr(5'(i), 5'd0, 5'd0, 1'b0, 1'b1);
            cyc();
        end
        instr(5'd4, 5'd1, 5'd0, 1'b0, 1'b0);
        #1 check("rs_stall", 32'(stall_o), 32'd1);
        cyc();
        reset = 1'b1;
        #1 check("rs_mid_issue", 32'(issue_valid), 32'd0);
        check("rs_mid_stall", 32'(stall_o), 32'd0);
        cyc();
        reset = 1'b0;
        check("rs_pending", pending_o, 32'h0);
        check("rs_cnt", 32'(load_cnt_o), 32'd0);
        check("rs_flush", 32'(flush_o), 32'd0);
        #1 check("rs_reissue", 32'(issue_valid), 32'd1);
        cyc();
        redirect_valid = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        check("rsf_flush", 32'(flush_o), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rsf_flush_abort", 32'(flush_o), 32'd0);
        #1 check("rsf_issue", 32'(issue_valid), 32'd1);
        cyc();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_issue_controller.md
Name: decode_issue_controller

Overview:
- Sequences the decode stage of the in-order RV32I pipeline.
- Sits between the decoder's control word and the execute-stage issue register.
- Keeps a per-register load scoreboard, detects load-use hazards, and limits the number of outstanding loads.
- Applies a timed flush window on branch/jump redirect, and generates the decode stall, issue valid and upstream ready signals.

Parameters:
- REG_COUNT, 32, architectural integer registers; sets scoreboard width and address width $clog2(REG_COUNT).
- MAX_LOADS, 4, maximum loads issued but not yet written back; range 1..15.
- FLUSH_CYCLES, 2, cycles the flush stays asserted after a redirect; range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- dec_valid  in  1  decoder holds a valid instruction.
- dec_ready  out  1  controller accepts the decoded instruction this cycle.
- dec_d_addr  in  5  destination register; 0 when the instruction does not write.
- dec_a_sel  in  5  rs1 address.
- dec_b_sel  in  5  rs2 address.
- dec_uses_b  in  1  rs2 is really read (R/S/B types).
- dec_load  in  1  instruction is a load.
- ex_ready  in  1  execute stage can take an instruction.
- issue_valid  out  1  instruction issued to execute this cycle.
- redirect_valid  in  1  taken branch/JAL/JALR resolved in execute.
- wb_valid  in  1  writeback event this cycle.
- wb_load  in  1  the writeback is load data.
- wb_addr  in  5  writeback destination.
- stall_o  out  1  decode hold (hazard, load limit or ex backpressure).
- flush_o  out  1  kill the fetch/decode contents.
- pending_o  out  REG_COUNT  scoreboard vector, for trace/debug.
- load_cnt_o  out  4  outstanding load count.

Behaviour:
- States: RUN, STALL, FLUSH, encoded 2 bits. Reset enters RUN.
- Reset values: pending_o=0, load_cnt_o=0, flush counter=0, flush_o=0. The combinational outputs issue_valid, dec_ready and stall_o evaluate to 0 during reset.
- A reset asserted mid-flush or mid-stall aborts it within one cycle; all outstanding loads are forgotten.
- Effective clear: clr[r] = wb_valid & wb_load & (wb_addr==r) & (r!=0).
- Load-use bypass: pending_eff = pending & ~clr. A writeback arriving this cycle resolves the hazard in the same cycle, so it does not stall.
- Hazard condition: haz = pending_eff[a_sel] | (dec_uses_b & pending_eff[b_sel]).
  - Register 0 is never pending.
  - dec_uses_b=0 ignores b_sel.
- Load limit: lim = dec_load & (load_cnt_o == MAX_LOADS) & ~(a load writeback this cycle).
- Issue rule: issue_valid = dec_valid & ex_ready & ~haz & ~lim & (state != FLUSH) & ~redirect_valid & ~reset.
  - dec_ready = issue_valid.
  - stall_o = dec_valid & ~issue_valid & (state != FLUSH).
- Scoreboard next state: pending <= (pending & ~clr) | set.
  - set = one-hot(dec_d_addr) when issue_valid & dec_load & dec_d_addr != 0.
  - If set and clear hit the same register in one cycle, the bit stays 1 (the new load wins).
- load_cnt next state: +1 on a load issue, -1 on a load writeback, unchanged when both happen.
  - A load writeback while load_cnt_o=0 is a protocol error; the counter saturates at 0.
- State transitions:
  - RUN -> STALL when stall_o=1.
  - STALL -> RUN on the first issue_valid, or when dec_valid drops.
  - Any state -> FLUSH when redirect_valid=1: flush counter loads FLUSH_CYCLES and flush_o=1 from the next cycle.
  - FLUSH: flush_o=1; the counter decrements each cycle; leave to RUN when it reaches 1.
  - redirect_valid during FLUSH reloads the counter.
- The flush never touches the scoreboard: loads already issued are older than the branch and still write back.
- No issue occurs in the redirect cycle itself.
- Latency: a hazard-free instruction issues in the same cycle (0 added latency). A stalled instruction issues in the cycle its load writeback arrives.

Decomposition:
- Shared package decode_ctrl_pkg:
  - state enum dec_ctrl_state_t {RUN, STALL, FLUSH}.
  - constant REG_ADDR_W=5.
  - localparams for the control_word field offsets (d_addr 25:21, b_select 20:16, a_select 15:11, load bit 4), so the top level can slice the decoder word.
- One sub-module: load_scoreboard. It holds the REG_COUNT pending bits, the bypass and the load counter; its outputs are pending_eff, load_cnt and a full flag. The FSM and issue logic stay in the parent.

Test Plan:
1. Load-use: issue `lw x5` (d=5, load=1), next cycle `add x6,x5,x1` with dec_uses_b=1 and no writeback → stall_o=1, issue_valid=0, pending_o[5]=1. Then wb_valid=1, wb_load=1, wb_addr=5 → issue_valid=1 in that same cycle, and pending_o[5]=0 the next cycle.
2. x0 and unused rs2: `lw x0` followed by `addi x7,x0,1`; also a pending x9 with b_sel=9 and dec_uses_b=0 → no stall in either case, pending_o stays 0 for bit 0.
3. Load limit, MAX_LOADS=4: issue 4 loads to x1..x4 with no writebacks; a 5th load to x8 → stall. A writeback of x1 in the same cycle → the 5th load issues and load_cnt_o stays 4.
4. Same-register set/clear: wb of x5 in the same cycle a new `lw x5` issues → pending_o[5]=1 afterwards, load_cnt_o unchanged.
5. Redirect: redirect_valid pulse with FLUSH_CYCLES=2 while dec_valid=1 → issue_valid=0 that cycle, flush_o=1 for exactly 2 cycles, then RUN. Pending loads still clear on their writeback.
6. Reset mid-operation: 3 loads outstanding in STALL, assert reset for 1 cycle → pending_o=0, load_cnt_o=0, flush_o=0, state RUN; the next hazard-free instruction issues immediately.
